comp_serial_lsb: RTL and testbench

Sequential bit-serial magnitude comparator that evaluates two WIDTH-bit unsigned operands LSB-first, one bit per clock. It is the reverse-direction counterpart of the combinational MSB-down comparator cascade. It uses the same one-hot greater/equal/less result encoding. It is used where area matters more than latency, with a valid/ready handshake on both the operand side and the result side.

---
 rtl/comp_pkg.sv | 35 +++
 rtl/comp_serial_cell.sv | 21 ++
 rtl/comp_serial_lsb.sv | 129 ++++++++++++
 tb/tb_comp_serial_lsb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package comp_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Encoded comparison result; 2'b11 never occurs.
  typedef enum logic [1:0] {
    RES_EQ = 2'b00,
    RES_GT = 2'b01,
    RES_LT = 2'b10
  } res_e;

  // Decode an encoded result to one-hot {gout, eout, lout}.
  function automatic logic [2:0] res_decode(input logic [1:0] r);
    logic [2:0] gel;
    case (r)
      RES_EQ:  gel = 3'b010;
      RES_GT:  gel = 3'b100;
      RES_LT:  gel = 3'b001;
      default: gel = 3'b000;
    endcase
    return gel;
  endfunction

  // Bit-counter width: clog2(w), never below one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/comp_serial_cell.sv
// One LSB-first update step: a differing bit overrides whatever the lower bits decided.
module comp_serial_cell
  import comp_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic [1:0] part_in,
  output logic [1:0] part_out
);

  // Later (more significant) differing bits take precedence over the carried partial.
  always_comb begin
    part_out = part_in;
    if (a_bit && !b_bit) begin
      part_out = RES_GT;
    end else if (!a_bit && b_bit) begin
      part_out = RES_LT;
    end
  end

endmodule

// File: rtl/comp_serial_lsb.sv
// Bit-serial unsigned magnitude comparator, LSB first, one bit per clock,
// valid/ready handshake on operands and result.
module comp_serial_lsb
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gout,
  output logic             eout,
  output logic             lout
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       part_q, part_d;
  logic [2:0]       gel_q, gel_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       part_nxt;

  comp_serial_cell u_cell (
    .a_bit    (a_sr_q[0]),
    .b_bit    (b_sr_q[0]),
    .part_in  (part_q),
    .part_out (part_nxt)
  );

  // State register; async reset discards any comparison in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, fixed WIDTH cycles in RUN, wait for consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: ready only in IDLE and never while reset is held.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = out_valid_q;
    gout      = gel_q[2];
    eout      = gel_q[1];
    lout      = gel_q[0];
  end

  // Datapath next values: capture, shift/count/update, register result, clear on handshake.
  always_comb begin
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    cnt_d       = cnt_q;
    part_d      = part_q;
    gel_d       = gel_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d = a;
          b_sr_d = b;
          cnt_d  = '0;
          part_d = RES_EQ;
        end
      end
      ST_RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        part_d = part_nxt;
        if (cnt_q == CNT_LAST) begin
          gel_d       = res_decode(part_nxt);
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          gel_d       = 3'b000;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        gel_d       = 3'b000;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; all clear on reset so no stale result survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      cnt_q       <= '0;
      part_q      <= RES_EQ;
      gel_q       <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      cnt_q       <= cnt_d;
      part_q      <= part_d;
      gel_q       <= gel_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_comp_serial_lsb.sv
// Randomized and directed bench for comp_serial_lsb at WIDTH = 1, 4 and 8.
module tb_comp_serial_lsb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int   wid [3] = '{1, 4, 8};
  logic iv  [3];
  logic orr [3];
  logic ir  [3];
  logic ov  [3];
  logic g   [3];
  logic e   [3];
  logic l   [3];

  logic [0:0] a0, b0;
  logic [3:0] a1, b1;
  logic [7:0] a2, b2;

  comp_serial_lsb #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a0), .b(b0),
    .out_valid(ov[0]), .out_ready(orr[0]), .gout(g[0]), .eout(e[0]), .lout(l[0])
  );
  comp_serial_lsb #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a1), .b(b1),
    .out_valid(ov[1]), .out_ready(orr[1]), .gout(g[1]), .eout(e[1]), .lout(l[1])
  );
  comp_serial_lsb #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a2), .b(b2),
    .out_valid(ov[2]), .out_ready(orr[2]), .gout(g[2]), .eout(e[2]), .lout(l[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference: plain unsigned comparison of the operands truncated to the DUT width.
  function automatic logic [2:0] model_gel(input int w, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m, am, bm;
    m  = (32'h1 << w) - 32'h1;
    am = a & m;
    bm = b & m;
    if (am > bm) return 3'b100;
    if (am == bm) return 3'b010;
    return 3'b001;
  endfunction

  task automatic set_ops(input int d, input logic [31:0] a, input logic [31:0] b);
    case (d)
      0:       begin a0 = a[0:0]; b0 = b[0:0]; end
      1:       begin a1 = a[3:0]; b1 = b[3:0]; end
      default: begin a2 = a[7:0]; b2 = b[7:0]; end
    endcase
  endtask

  function automatic logic [2:0] gel_of(input int d);
    return {g[d], e[d], l[d]};
  endfunction

  // Accept one operand pair, optionally pulse in_valid while busy, hold the result, then release it.
  task automatic run_cmp(input int d, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit pulse);
    logic [2:0] exp;
    int n;
    exp = model_gel(wid[d], a, b);
    check_eq($sformatf("in_ready_idle_w%0d", wid[d]), 32'(ir[d]), 32'd1);
    set_ops(d, a, b);
    iv[d]  = 1'b1;
    orr[d] = 1'b0;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    check_eq($sformatf("in_ready_busy_w%0d", wid[d]), 32'(ir[d]), 32'd0);
    n = 0;
    while (!ov[d] && n < 100) begin
      check_eq($sformatf("gel_zero_run_w%0d", wid[d]), 32'(gel_of(d)), 32'd0);
      if (pulse) begin
        iv[d] = 1'($urandom_range(0, 1));
        set_ops(d, $urandom, $urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    check_eq($sformatf("latency_w%0d", wid[d]), 32'(n), 32'(wid[d]));
    check_eq($sformatf("result_w%0d_a%0h_b%0h", wid[d], a, b), 32'(gel_of(d)), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        iv[d] = 1'($urandom_range(0, 1));
        set_ops(d, $urandom, $urandom);
      end
      @(posedge clk); #1;
      check_eq($sformatf("hold_valid_w%0d", wid[d]), 32'(ov[d]), 32'd1);
      check_eq($sformatf("hold_result_w%0d", wid[d]), 32'(gel_of(d)), 32'(exp));
      check_eq($sformatf("hold_in_ready_w%0d", wid[d]), 32'(ir[d]), 32'd0);
    end
    iv[d]  = 1'b0;
    orr[d] = 1'b1;
    @(posedge clk); #1;
    orr[d] = 1'b0;
    check_eq($sformatf("release_valid_w%0d", wid[d]), 32'(ov[d]), 32'd0);
    check_eq($sformatf("release_gel_w%0d", wid[d]), 32'(gel_of(d)), 32'd0);
    check_eq($sformatf("release_in_ready_w%0d", wid[d]), 32'(ir[d]), 32'd1);
    if (pulse) begin
      repeat (wid[d] + 2) @(posedge clk);
      #1;
      check_eq($sformatf("no_second_result_w%0d", wid[d]), 32'(ov[d]), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [31:0] ra, rb;
    for (int i = 0; i < 3; i++) begin
      iv[i]  = 1'b0;
      orr[i] = 1'b0;
    end
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;

    // Reset held with in_valid asserted: nothing may start.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) iv[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("reset_valid_w%0d", wid[i]), 32'(ov[i]), 32'd0);
      check_eq($sformatf("reset_gel_w%0d", wid[i]), 32'(gel_of(i)), 32'd0);
      iv[i] = 1'b0;
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("post_reset_in_ready_w%0d", wid[i]), 32'(ir[i]), 32'd1);

    // Directed cases.
    run_cmp(1, 32'b1010, 32'b0111, 0, 1'b0);
    run_cmp(1, 32'b0001, 32'b1000, 0, 1'b0);
    run_cmp(1, 32'b0110, 32'b0110, 0, 1'b0);
    run_cmp(1, 32'd3, 32'd5, 3, 1'b1);
    run_cmp(2, 32'hFF, 32'h00, 10, 1'b0);
    run_cmp(0, 32'd1, 32'd0, 1, 1'b0);
    run_cmp(0, 32'd0, 32'd1, 0, 1'b0);
    run_cmp(0, 32'd1, 32'd1, 0, 1'b0);

    // Reset three cycles into a comparison: the result must never appear.
    set_ops(2, 32'h80, 32'h7F);
    iv[2] = 1'b1;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_midrun_valid", 32'(ov[2]), 32'd0);
    check_eq("rst_midrun_gel", 32'(gel_of(2)), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("rst_midrun_no_result", 32'(ov[2]), 32'd0);
    run_cmp(2, 32'd2, 32'd2, 0, 1'b0);

    // Reset while a result is pending: out_valid drops without a clock edge.
    set_ops(2, 32'hFF, 32'h00);
    iv[2] = 1'b1;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_rst_done_valid", 32'(ov[2]), 32'd1);
    check_eq("pre_rst_done_gel", 32'(gel_of(2)), 32'b100);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_done_valid", 32'(ov[2]), 32'd0);
    check_eq("rst_done_gel", 32'(gel_of(2)), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_eq("rst_done_in_ready", 32'(ir[2]), 32'd1);
    run_cmp(2, 32'h7F, 32'h80, 0, 1'b0);

    // Randomized comparisons across all widths.
    for (int k = 0; k < 40; k++) begin
      d  = $urandom_range(0, 2);
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_cmp(d, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
